// File: rtl/rx_packet_parser.sv
// rtl/rx_packet_parser.sv - receive packet parser feeding the cost-learning stage (optional checksum: RXP_CHECKSUM_EN)
module rx_packet_parser #(
   parameter logic [11:0] NODE_ID  = 12'd1,
   parameter logic [3:0]  PKT_TYPE = 4'h1
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   output logic        in_ready,
   output logic        start,
   output logic [15:0] fsourceID,
   output logic [15:0] fbatteryStat,
   output logic [15:0] fValue,
   output logic [15:0] fclusterID,
   input  logic        done,
   output logic [7:0]  drop_count
);

`ifdef RXP_CHECKSUM_EN
   // DISCARD must also swallow the trailing checksum word, so the counter needs a third bit
   localparam int            CNT_W     = 3;
   localparam logic [CNT_W-1:0] DISC_LAST = 3'd4;
`else
   localparam int            CNT_W     = 2;
   localparam logic [CNT_W-1:0] DISC_LAST = 2'd3;
`endif

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PAYLOAD = 3'd1,
`ifdef RXP_CHECKSUM_EN
      S_CHECK   = 3'd2,
`endif
      S_ISSUE   = 3'd3,
      S_DISCARD = 3'd4
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             in_ready_q;
   logic             start_q;
   logic [15:0]      sh_src_q, sh_bat_q, sh_val_q, sh_clus_q;
   logic [15:0]      f_src_q, f_bat_q, f_val_q, f_clus_q;
   logic [7:0]       drop_q;
`ifdef RXP_CHECKSUM_EN
   logic [15:0]      csum_q;
`endif
   logic             hdr_ok;
   logic [CNT_W-1:0] cnt_inc;

   // header match: right packet type, addressed to us or broadcast
   always_comb begin
      hdr_ok  = (in_data[15:12] == PKT_TYPE) &&
                ((in_data[11:0] == NODE_ID) || (in_data[11:0] == 12'hFFF));
      cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   // parser FSM with registered handshake, request and field outputs
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         in_ready_q <= 1'b1;
         start_q    <= 1'b0;
         sh_src_q   <= '0;
         sh_bat_q   <= '0;
         sh_val_q   <= '0;
         sh_clus_q  <= '0;
         f_src_q    <= '0;
         f_bat_q    <= '0;
         f_val_q    <= '0;
         f_clus_q   <= '0;
         drop_q     <= '0;
`ifdef RXP_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  cnt_q <= '0;
`ifdef RXP_CHECKSUM_EN
                  csum_q <= in_data;
`endif
                  state_q <= hdr_ok ? S_PAYLOAD : S_DISCARD;
               end
            end
            S_PAYLOAD: begin
               if (in_valid) begin
                  cnt_q <= cnt_inc;
`ifdef RXP_CHECKSUM_EN
                  csum_q <= csum_q ^ in_data;
`endif
                  case (cnt_q[1:0])
                     2'd0:    sh_src_q <= in_data;
                     2'd1:    sh_bat_q <= in_data;
                     2'd2:    sh_val_q <= in_data;
                     default: sh_clus_q <= in_data;
                  endcase
                  if (cnt_q[1:0] == 2'd3) begin
`ifdef RXP_CHECKSUM_EN
                     state_q <= S_CHECK;
`else
                     // last word goes straight to the outputs so start rises on this edge
                     state_q    <= S_ISSUE;
                     in_ready_q <= 1'b0;
                     start_q    <= 1'b1;
                     f_src_q    <= sh_src_q;
                     f_bat_q    <= sh_bat_q;
                     f_val_q    <= sh_val_q;
                     f_clus_q   <= in_data;
`endif
                  end
               end
            end
`ifdef RXP_CHECKSUM_EN
            S_CHECK: begin
               if (in_valid) begin
                  if (in_data == csum_q) begin
                     state_q    <= S_ISSUE;
                     in_ready_q <= 1'b0;
                     start_q    <= 1'b1;
                     f_src_q    <= sh_src_q;
                     f_bat_q    <= sh_bat_q;
                     f_val_q    <= sh_val_q;
                     f_clus_q   <= sh_clus_q;
                  end else begin
                     state_q <= S_IDLE;
                     if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
                  end
               end
            end
`endif
            S_ISSUE: begin
               if (done) begin
                  state_q    <= S_IDLE;
                  start_q    <= 1'b0;
                  in_ready_q <= 1'b1;
               end
            end
            S_DISCARD: begin
               if (in_valid) begin
                  if (cnt_q == DISC_LAST) begin
                     state_q <= S_IDLE;
                     if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
            end
            default: begin
               state_q    <= S_IDLE;
               in_ready_q <= 1'b1;
               start_q    <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready     = in_ready_q;
   assign start        = start_q;
   assign fsourceID    = f_src_q;
   assign fbatteryStat = f_bat_q;
   assign fValue       = f_val_q;
   assign fclusterID   = f_clus_q;
   assign drop_count   = drop_q;

endmodule
